riscv_crypto_sbox_seq: RTL and testbench

RISCV_CRYPTO_SBOX_SEQ -- requirements
Module: riscv_crypto_sbox_seq

---
 rtl/riscv_crypto_sbox_seq.sv | 124 ++++++++++++
 tb/tb_riscv_crypto_sbox_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_crypto_sbox_seq.sv
// Byte-serial sequencer for a shared AES/SM4 S-box: feeds one byte per cycle
// to the external combinational S-box and assembles the substituted word.
//
// state | meaning
// IDLE  | ready for a request; S-box controls idle
// BUSY  | one byte per cycle through the S-box, written into result
// DONE  | result held until the consumer takes it
module riscv_crypto_sbox_seq #(
  parameter int SINGLE_EN = 1
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_aes,
  input  logic        op_sm4,
  input  logic        op_dec,
  input  logic        op_single,
  input  logic [1:0]  bs,
  input  logic [31:0] rs1,
  output logic [7:0]  sbox_in,
  output logic        sbox_aes,
  output logic        sbox_sm4,
  output logic        sbox_dec,
  input  logic [7:0]  sbox_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_word;
  logic [31:0] r_result;
  logic [1:0]  r_cnt;
  logic        r_aes;
  logic        r_sm4;
  logic        r_dec;
  logic        r_single;
  logic        w_busy;
  logic        w_single;
  logic        w_last;
  logic        w_sel_aes;
  logic        w_sel_sm4;
  logic [7:0]  w_byte;

  // AES has priority; a request naming neither algorithm falls back to SM4.
  assign w_sel_aes = op_aes;
  assign w_sel_sm4 = (op_sm4 & ~op_aes) | ~(op_aes | op_sm4);
  assign w_single  = (SINGLE_EN != 0) && op_single;
  assign w_busy    = (r_state == BUSY);
  assign w_last    = r_single || (r_cnt == 2'd3);

  always_comb begin
    w_byte = r_word[7:0];
    case (r_cnt)
      2'd0: w_byte = r_word[7:0];
      2'd1: w_byte = r_word[15:8];
      2'd2: w_byte = r_word[23:16];
      2'd3: w_byte = r_word[31:24];
      default: w_byte = r_word[7:0];
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid)  w_next = BUSY;
      BUSY: if (w_last)    w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_result <= 32'h0;
      r_word   <= 32'h0;
      r_aes    <= 1'b0;
      r_sm4    <= 1'b0;
      r_dec    <= 1'b0;
      r_single <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word   <= rs1;
            r_aes    <= w_sel_aes;
            r_sm4    <= w_sel_sm4;
            r_dec    <= w_sel_aes & op_dec;
            r_single <= w_single;
            r_cnt    <= w_single ? bs : 2'd0;
            r_result <= 32'h0;
          end
        end
        BUSY: begin
          // Single mode always lands in the low byte; upper bytes stay cleared.
          if (r_single) r_result[7:0] <= sbox_out;
          else          r_result[{r_cnt, 3'b000} +: 8] <= sbox_out;
          if (!w_last) r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sbox_in   = w_busy ? w_byte : 8'h00;
  assign sbox_aes  = w_busy & r_aes;
  assign sbox_sm4  = w_busy & r_sm4;
  assign sbox_dec  = w_busy & r_dec;
  assign result    = r_result;

endmodule

// File: tb/tb_riscv_crypto_sbox_seq.sv
// Self-checking bench for riscv_crypto_sbox_seq: behavioural AES/SM4 S-box,
// table vectors, randomized ops against a word-level model, corner sequences.
module tb_riscv_crypto_sbox_seq;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        in_valid, op_aes, op_sm4, op_dec, op_single, out_ready;
  logic [1:0]  bs;
  logic [31:0] rs1;
  logic        in_ready, sbox_aes, sbox_sm4, sbox_dec, out_valid;
  logic [7:0]  sbox_in, sbox_out;
  logic [31:0] result;

  logic        iv1, ir1, sa1, ss1, sd1, ov1, or1;
  logic [7:0]  si1, so1;
  logic [31:0] res1;

  int checks = 0;
  int failures = 0;

  logic [7:0] aes_fwd [256];
  logic [7:0] aes_inv [256];
  logic [7:0] sm4_tab [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  typedef struct {
    logic        aes;
    logic        sm4;
    logic        dec;
    logic        single;
    logic [1:0]  bs;
    logic [31:0] rs1;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  // external combined S-box, one per DUT
  assign sbox_out = sbox_aes ? (sbox_dec ? aes_inv[sbox_in] : aes_fwd[sbox_in])
                             : (sbox_sm4 ? sm4_tab[sbox_in] : 8'h00);
  assign so1      = sa1 ? (sd1 ? aes_inv[si1] : aes_fwd[si1])
                        : (ss1 ? sm4_tab[si1] : 8'h00);

  riscv_crypto_sbox_seq #(.SINGLE_EN(1)) u_dut (
    .g_clk(g_clk), .g_rst(g_rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_aes(op_aes), .op_sm4(op_sm4), .op_dec(op_dec), .op_single(op_single),
    .bs(bs), .rs1(rs1), .sbox_in(sbox_in), .sbox_aes(sbox_aes), .sbox_sm4(sbox_sm4),
    .sbox_dec(sbox_dec), .sbox_out(sbox_out), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  riscv_crypto_sbox_seq #(.SINGLE_EN(0)) u_dut_nosingle (
    .g_clk(g_clk), .g_rst(g_rst), .in_valid(iv1), .in_ready(ir1),
    .op_aes(op_aes), .op_sm4(op_sm4), .op_dec(op_dec), .op_single(op_single),
    .bs(bs), .rs1(rs1), .sbox_in(si1), .sbox_aes(sa1), .sbox_sm4(ss1),
    .sbox_dec(sd1), .sbox_out(so1), .out_valid(ov1),
    .out_ready(or1), .result(res1)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b, input logic aes, input logic dec);
    if (aes) return dec ? aes_inv[b] : aes_fwd[b];
    return sm4_tab[b];
  endfunction

  function automatic void ref_op(input vec_t v, input bit single_en,
                                 output logic [31:0] r, output int lat);
    r = 32'h0;
    if (single_en && v.single) begin
      r[7:0] = sbox_ref(v.rs1[int'(v.bs)*8 +: 8], v.aes, v.aes & v.dec);
      lat = 2;
    end else begin
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox_ref(v.rs1[i*8 +: 8], v.aes, v.aes & v.dec);
      lat = 5;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One op on the SINGLE_EN=1 instance; checks the S-box byte sequence cycle by cycle.
  task automatic run_op(input vec_t v, input bit release_out, output logic [31:0] res,
                        output int lat, output int seq_err);
    int cyc;
    int idx;
    bit exp_busy_aes;
    seq_err = 0;
    lat = -1;
    res = 32'hx;
    cyc = 0;
    exp_busy_aes = v.aes;
    @(negedge g_clk);
    op_aes = v.aes; op_sm4 = v.sm4; op_dec = v.dec; op_single = v.single;
    bs = v.bs; rs1 = v.rs1; in_valid = 1'b1;
    if (sbox_in !== 8'h00 || sbox_aes || sbox_sm4 || sbox_dec || !in_ready) seq_err++;
    while (lat < 0 && cyc < 20) begin
      @(posedge g_clk);
      @(negedge g_clk);
      cyc++;
      if (cyc == 1) begin
        in_valid = 1'b0;
        rs1 = $urandom;
        {op_aes, op_sm4, op_dec, op_single} = 4'($urandom);
        bs = 2'($urandom);
      end
      if (release_out) out_ready = 1'($urandom_range(0, 1));
      if (out_valid) begin
        lat = cyc;
        res = result;
        if (sbox_in !== 8'h00 || sbox_aes || sbox_sm4 || sbox_dec || in_ready) seq_err++;
      end else begin
        idx = v.single ? int'(v.bs) : ((cyc - 1) & 3);
        if (sbox_in !== v.rs1[idx*8 +: 8]) seq_err++;
        if (sbox_aes !== exp_busy_aes || sbox_sm4 !== !exp_busy_aes) seq_err++;
        if (sbox_dec !== (v.aes & v.dec)) seq_err++;
        if (in_ready) seq_err++;
      end
    end
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge g_clk);
      @(negedge g_clk);
      out_ready = 1'b0;
      if (!in_ready || out_valid) seq_err++;
    end else begin
      out_ready = 1'b0;
    end
  endtask

  vec_t        tab [9];
  vec_t        v;
  logic [31:0] res, exp_r, held;
  int          lat, exp_l, se, err, cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      aes_fwd[x] = s;
      aes_inv[s] = x[7:0];
    end

    tab[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00112233, 32'h638293C3, 5};
    tab[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h63636363, 32'h00000000, 5};
    tab[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00000001, 32'hD6D6D690, 5};
    tab[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000001, 32'hD6D6D690, 5};
    tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h00110000, 32'h00000082, 2};
    tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00112233, 32'h638293C3, 5};
    tab[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hFFFFFF01, 32'h00000090, 2};
    tab[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 32'h63AABBCC, 32'h00000000, 2};
    tab[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h00000000, 32'hD6D6D6D6, 5};

    g_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    op_aes = 1'b0; op_sm4 = 1'b0; op_dec = 1'b0; op_single = 1'b0; bs = 2'd0; rs1 = 32'h0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    g_rst = 1'b0;
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_sbox_ctl", {21'h0, sbox_aes, sbox_sm4, sbox_dec, sbox_in}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      run_op(tab[i], 1'b1, res, lat, se);
      chk($sformatf("vec%0d_result", i), res, tab[i].exp_res);
      chk($sformatf("vec%0d_latency", i), lat, tab[i].exp_lat);
      chk($sformatf("vec%0d_sbox_seq", i), se, 0);
    end

    for (int i = 0; i < 30; i++) begin
      v.aes = 1'($urandom); v.sm4 = 1'($urandom); v.dec = 1'($urandom);
      v.single = 1'($urandom); v.bs = 2'($urandom); v.rs1 = $urandom;
      ref_op(v, 1'b1, exp_r, exp_l);
      v.exp_res = exp_r; v.exp_lat = exp_l;
      run_op(v, 1'b1, res, lat, se);
      chk($sformatf("rand%0d_result", i), res, exp_r);
      chk($sformatf("rand%0d_latency", i), lat, exp_l);
      chk($sformatf("rand%0d_sbox_seq", i), se, 0);
    end

    // backpressure: hold DONE for 10 cycles, then release with a competing request
    run_op(tab[0], 1'b0, res, lat, se);
    chk("bp_result", res, 32'h638293C3);
    held = res;
    err = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i & 1);
      rs1 = $urandom;
      @(posedge g_clk);
      @(negedge g_clk);
      if (result !== held || !out_valid || in_ready) err++;
    end
    chk("bp_hold", err, 0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_bubble_idle", {30'h0, in_ready, out_valid}, 32'h2);
    @(posedge g_clk);
    @(negedge g_clk);
    chk("bp_still_idle", {31'h0, in_ready}, 32'h1);

    // reset wins over a simultaneous request
    in_valid = 1'b1; g_rst = 1'b1; rs1 = 32'h00112233; op_aes = 1'b1; op_single = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0; g_rst = 1'b0;
    chk("rst_prio_in_ready", {31'h0, in_ready}, 32'h1);

    // reset in BUSY after byte 1 has been written
    op_aes = 1'b1; op_sm4 = 1'b0; op_dec = 1'b0; op_single = 1'b0; rs1 = 32'h00112233;
    in_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    @(posedge g_clk);
    @(negedge g_clk);
    g_rst = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    g_rst = 1'b0;
    chk("rst_busy_result", result, 32'h0);
    chk("rst_busy_flags", {30'h0, in_ready, out_valid}, 32'h2);
    run_op(tab[0], 1'b1, res, lat, se);
    chk("post_rst_result", res, 32'h638293C3);
    chk("post_rst_latency", lat, 5);

    // SINGLE_EN=0 instance runs a single request as a full word
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h00110000, 32'h0, 0};
    ref_op(v, 1'b0, exp_r, exp_l);
    @(negedge g_clk);
    op_aes = 1'b1; op_sm4 = 1'b0; op_dec = 1'b0; op_single = 1'b1; bs = 2'd2;
    rs1 = 32'h00110000; iv1 = 1'b1;
    cyc = 0;
    lat = -1;
    while (lat < 0 && cyc < 20) begin
      @(posedge g_clk);
      @(negedge g_clk);
      cyc++;
      iv1 = 1'b0;
      if (ov1) begin
        lat = cyc;
        res = res1;
      end
    end
    chk("nosingle_result", res, 32'h63826363);
    chk("nosingle_model", res, exp_r);
    chk("nosingle_latency", lat, exp_l);
    or1 = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    or1 = 1'b0;
    chk("nosingle_idle", {30'h0, ir1, ov1}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
